bit_unstuffer: RTL and testbench

BIT_UNSTUFFER -- requirements
Module: bit_unstuffer

---
 rtl/usb_pkg.sv | 25 ++
 rtl/rx_byte_assembler.sv | 51 +++++
 rtl/bit_unstuffer.sv | 116 +++++++++++
 tb/tb_bit_unstuffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive bit-unstuffing path.
// Holds the unstuffer state encoding and the stuffing / byte geometry.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STUFF = 2'd2,
    ERR   = 2'd3
  } state_t;

  localparam int STUFF_RUN_LEN = 6;
  localparam int BYTE_W        = 8;
  localparam int BIT_CNT_W     = $clog2(BYTE_W);
  localparam int ONES_W        = 3;

  // Next ones-run count after an accepted '1'; clamps so it can never pass the run limit.
  function automatic logic [ONES_W-1:0] ones_step(input logic [ONES_W-1:0] cnt);
    if (cnt >= ONES_W'(STUFF_RUN_LEN)) begin
      return ONES_W'(STUFF_RUN_LEN);
    end
    return cnt + ONES_W'(1);
  endfunction

endpackage

// File: rtl/rx_byte_assembler.sv
// Collects forwarded payload bits (LSB first) into bytes.
// byte_out only changes when a byte completes; clr drops any partial byte.
module rx_byte_assembler
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid
);

  logic [BIT_CNT_W-1:0] bit_cnt_reg;
  logic [BYTE_W-1:0]    shift_reg;
  logic [BYTE_W-1:0]    byte_next;
  logic                 last_bit;

  // The completing bit lands directly in the output word, so byte_out
  // is ready in the same cycle as that bit's data_ready.
  for (genvar gi = 0; gi < BYTE_W; gi++) begin : g_byte_next
    assign byte_next[gi] = (bit_cnt_reg == BIT_CNT_W'(gi)) ? bit_in : shift_reg[gi];
  end

  assign last_bit = (bit_cnt_reg == BIT_CNT_W'(BYTE_W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      byte_out    <= '0;
      byte_valid  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      if (clr) begin
        bit_cnt_reg <= '0;
      end else if (bit_valid) begin
        shift_reg <= byte_next;
        if (last_bit) begin
          byte_out    <= byte_next;
          byte_valid  <= 1'b1;
          bit_cnt_reg <= '0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/bit_unstuffer.sv
// USB receive bit unstuffer: removes the 0 inserted after six 1s and flags stuff violations.
// Optional macro STUFF_ERR_CNT_EN adds a saturating err_count output.
module bit_unstuffer
  import usb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_active,
  input  logic              data_valid,
  input  logic              data_in,
  output logic              unstuffed_data_out,
  output logic              data_ready,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              stuff_err
`ifdef STUFF_ERR_CNT_EN
  ,
  output logic [7:0]        err_count
`endif
);

  state_t              state_reg, state_next;
  logic [ONES_W-1:0]   ones_reg, ones_next;
  logic                fwd;
  logic                err_hit;
  logic                asm_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      ones_reg  <= '0;
    end else begin
      state_reg <= state_next;
      ones_reg  <= ones_next;
    end
  end

  // Packet end beats data_valid in every non-IDLE state.
  always_comb begin
    state_next = state_reg;
    ones_next  = ones_reg;
    fwd        = 1'b0;
    err_hit    = 1'b0;
    if (state_reg == IDLE) begin
      if (pkt_active) begin
        state_next = RUN;
        ones_next  = '0;
      end
    end else if (!pkt_active) begin
      state_next = IDLE;
      ones_next  = '0;
    end else if (data_valid) begin
      case (state_reg)
        RUN: begin
          fwd = 1'b1;
          if (!data_in) begin
            ones_next = '0;
          end else if (ones_reg == ONES_W'(STUFF_RUN_LEN - 1)) begin
            ones_next  = '0;
            state_next = STUFF;
          end else begin
            ones_next = ones_step(ones_reg);
          end
        end
        STUFF: begin
          if (data_in) begin
            err_hit    = 1'b1;
            state_next = ERR;
          end else begin
            state_next = RUN;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      unstuffed_data_out <= 1'b0;
      data_ready         <= 1'b0;
      stuff_err          <= 1'b0;
    end else begin
      data_ready <= fwd;
      stuff_err  <= err_hit;
      if (fwd) begin
        unstuffed_data_out <= data_in;
      end
    end
  end

  // Bit position restarts at every packet boundary, including IDLE->RUN.
  assign asm_clr = (state_reg == IDLE) || !pkt_active;

  rx_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .bit_valid  (fwd),
    .bit_in     (data_in),
    .byte_out   (byte_out),
    .byte_valid (byte_valid)
  );

`ifdef STUFF_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_count <= '0;
    end else if (err_hit && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bit_unstuffer.sv
// Self-checking bench for bit_unstuffer; expected bits/bytes are queued at drive time
// and popped by a monitor when the DUT qualifies output.
module tb_bit_unstuffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pkt_active = 1'b0;
  logic       data_valid = 1'b0;
  logic       data_in = 1'b0;
  logic       unstuffed_data_out;
  logic       data_ready;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       stuff_err;
`ifdef STUFF_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int failures = 0;
  bit mon_en = 1'b0;
  logic       exp_bits[$];
  logic [7:0] exp_bytes[$];

  always #5 clk = ~clk;

  bit_unstuffer dut (
    .clk                (clk),
    .rst                (rst),
    .pkt_active         (pkt_active),
    .data_valid         (data_valid),
    .data_in            (data_in),
    .unstuffed_data_out (unstuffed_data_out),
    .data_ready         (data_ready),
    .byte_out           (byte_out),
    .byte_valid         (byte_valid),
    .stuff_err          (stuff_err)
`ifdef STUFF_ERR_CNT_EN
    ,
    .err_count          (err_count)
`endif
  );

  // Scoreboard monitor: every qualified output must match the head of its queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (data_ready) begin
        checks++;
        if (exp_bits.size() == 0) begin
          failures++;
          $display("FAIL unexpected_data_ready got bit=%0b expected none", unstuffed_data_out);
        end else begin
          logic eb;
          eb = exp_bits.pop_front();
          if (unstuffed_data_out !== eb) begin
            failures++;
            $display("FAIL bit_value got=%0b expected=%0b", unstuffed_data_out, eb);
          end
        end
      end
      if (byte_valid) begin
        checks++;
        if (exp_bytes.size() == 0) begin
          failures++;
          $display("FAIL unexpected_byte_valid got=%02h expected none", byte_out);
        end else begin
          logic [7:0] ebyte;
          ebyte = exp_bytes.pop_front();
          if (byte_out !== ebyte || data_ready !== 1'b1) begin
            failures++;
            $display("FAIL byte_value got=%02h ready=%0b expected=%02h ready=1",
                     byte_out, data_ready, ebyte);
          end else begin
            $display("byte %02h", byte_out);
          end
        end
      end
    end
  end

  // One accepted-bit cycle; checks the outputs registered at that edge.
  task automatic send_bit(input logic b, input logic exp_fwd, input logic exp_err);
    data_valid = 1'b1;
    data_in    = b;
    if (exp_fwd) exp_bits.push_back(b);
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    checks++;
    if (data_ready !== exp_fwd || stuff_err !== exp_err) begin
      failures++;
      $display("FAIL bit_latency in=%0b got ready=%0b err=%0b expected ready=%0b err=%0b",
               b, data_ready, stuff_err, exp_fwd, exp_err);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (data_ready !== 1'b0 || stuff_err !== 1'b0) begin
        failures++;
        $display("FAIL gap_quiet got ready=%0b err=%0b expected 0 0", data_ready, stuff_err);
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    exp_bytes.push_back(v);
    for (int i = 0; i < 8; i++) begin
      send_bit(v[i], 1'b1, 1'b0);
      if (max_gap > 0 && i < 7) idle_cycles($urandom_range(max_gap, 1));
    end
  endtask

  task automatic start_pkt();
    pkt_active = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic end_pkt();
    pkt_active = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (exp_bits.size() != 0 || exp_bytes.size() != 0) begin
      failures++;
      $display("FAIL queues_drained got bits=%0d bytes=%0d expected 0 0",
               exp_bits.size(), exp_bytes.size());
      exp_bits.delete();
      exp_bytes.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (unstuffed_data_out !== 1'b0 || data_ready !== 1'b0 || byte_out !== 8'h00 ||
        byte_valid !== 1'b0 || stuff_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got out=%0b ready=%0b byte=%02h bv=%0b err=%0b expected all 0",
               unstuffed_data_out, data_ready, byte_out, byte_valid, stuff_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;
    $display("reset released");
  endtask

  task automatic test_idle_ignore();
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    $display("idle ignores data_valid");
  endtask

  task automatic test_zeros();
    start_pkt();
    send_byte(8'h00, 0);
    end_pkt();
    $display("zeros packet done");
  endtask

  task automatic test_stuff();
    start_pkt();
    exp_bytes.push_back(8'hFF);
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    end_pkt();
    $display("stuff bit removed");
  endtask

  task automatic test_violation();
    start_pkt();
    for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b1);
    send_bit(1'b0, 1'b0, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
    send_bit(1'b0, 1'b0, 1'b0);
    exp_bits.delete();
    end_pkt();
    start_pkt();
    send_byte(8'hA5, 0);
    end_pkt();
    $display("violation then recovery");
  endtask

  task automatic test_abort();
    start_pkt();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    pkt_active = 1'b0;
    send_bit(1'b1, 1'b0, 1'b0);
    end_pkt();
    start_pkt();
    send_byte(8'h3C, 0);
    end_pkt();
    $display("partial byte discarded");
  endtask

  task automatic test_gaps();
    start_pkt();
    send_byte(8'h5A, 3);
    send_byte(8'h96, 2);
    end_pkt();
    $display("gapped bytes done");
  endtask

  task automatic test_async_reset();
    start_pkt();
    send_bit(1'b1, 1'b1, 1'b0);
    send_bit(1'b1, 1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    exp_bits.delete();
    checks++;
    if (unstuffed_data_out !== 1'b0 || data_ready !== 1'b0 || byte_out !== 8'h00 ||
        byte_valid !== 1'b0 || stuff_err !== 1'b0) begin
      failures++;
      $display("FAIL async_reset got out=%0b ready=%0b byte=%02h bv=%0b err=%0b expected all 0",
               unstuffed_data_out, data_ready, byte_out, byte_valid, stuff_err);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    // First cycle after release is IDLE: the bit must be ignored.
    send_bit(1'b1, 1'b0, 1'b0);
    send_byte(8'hC3, 0);
    end_pkt();
    $display("async reset and restart done");
  endtask

`ifdef STUFF_ERR_CNT_EN
  task automatic test_err_count();
    for (int n = 0; n < 300; n++) begin
      start_pkt();
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b1, 1'b0);
      send_bit(1'b1, 1'b0, 1'b1);
      end_pkt();
    end
    checks++;
    if (err_count !== 8'd255) begin
      failures++;
      $display("FAIL err_count_sat got=%0d expected=255", err_count);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL err_count_clear got=%0d expected=0", err_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    $display("err_count saturation done");
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_zeros();
    test_stuff();
    test_violation();
    test_abort();
    test_gaps();
    test_async_reset();
`ifdef STUFF_ERR_CNT_EN
    test_err_count();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
